// File: rtl/ucaspian_synapse_if.sv
// Range request / dendrite output bundle between a spike router and the synapse stage.
// Latency: none, wires only.
// Backpressure: syn_rdy gates range requests, dend_rdy stalls the dendrite stream.
interface ucaspian_synapse_if;
  logic [11:0] syn_start;
  logic [11:0] syn_end;
  logic        syn_vld;
  logic        syn_rdy;
  logic [7:0]  dend_addr;
  logic [7:0]  dend_weight;
  logic        dend_vld;
  logic        dend_rdy;

  modport master (
    output syn_start, syn_end, syn_vld, dend_rdy,
    input  syn_rdy, dend_addr, dend_weight, dend_vld
  );

  modport slave (
    input  syn_start, syn_end, syn_vld, dend_rdy,
    output syn_rdy, dend_addr, dend_weight, dend_vld
  );
endinterface

// File: rtl/ucaspian_synapse.sv
// Walks a synapse index range through a 4096x16 RAM and streams (target, weight) pairs.
// Latency: first synapse 2 cycles after range acceptance, then one per cycle.
// Backpressure: dend_rdy low holds the 2-entry output FIFO; reads are throttled so it never overflows.
module ucaspian_synapse (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear_config,
  output logic              clear_done,
  input  logic [11:0]       config_addr,
  input  logic [7:0]        config_value,
  input  logic [2:0]        config_byte,
  input  logic              config_enable,
  input  logic              next_step,
  output logic              step_done,
  ucaspian_synapse_if.slave syn_if
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [11:0] idx, end_idx;
  logic        inflight;
  logic [15:0] rd_data;
  logic [15:0] ram [4096];
  logic [15:0] fifo_mem [2];
  logic        fifo_wr_ptr, fifo_rd_ptr;
  logic [1:0]  fifo_count;
  // Only the high byte needs holding: the low byte is written to RAM in the
  // same cycle it arrives, straight from config_value.
  logic [7:0]  staging_hi;
  logic [11:0] clr_ptr;
  logic        clr_finished;
  logic        abort, accept, push, pop, issue;
  logic [2:0]  occupancy;
  logic        ram_we;
  logic [11:0] ram_waddr;
  logic [15:0] ram_wdata;

  assign abort  = clear_config | next_step;
  assign syn_if.syn_rdy = reset && (state == IDLE) && enable && !clear_config;
  assign accept = syn_if.syn_vld && syn_if.syn_rdy;
  assign syn_if.dend_vld = (fifo_count != 2'd0);
  assign {syn_if.dend_addr, syn_if.dend_weight} = fifo_mem[fifo_rd_ptr];
  assign pop    = syn_if.dend_vld && syn_if.dend_rdy;
  assign push   = inflight;
  // The pop happening this cycle frees a slot before the new read lands two
  // edges later, so crediting it keeps one synapse per cycle under full flow.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue  = (state == RUN) && enable && !abort && (occupancy < 3'd2);

  // Range walker next state: abort always wins and returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (issue && (idx == end_idx)) state_nxt = DRAIN;
      DRAIN:   if (!inflight && ((fifo_count - {1'b0, pop}) == 2'd0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // State, range pointers and the read-in-flight flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      end_idx  <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (accept && !abort) begin
        idx     <= syn_if.syn_start;
        end_idx <= syn_if.syn_end;
      end else if (issue) begin
        idx <= idx + 12'd1;
      end
    end
  end

  // Output FIFO: read data lands here one cycle after the read; abort flushes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_wr_ptr <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_count  <= '0;
    end else if (abort) begin
      fifo_wr_ptr <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[fifo_wr_ptr] <= rd_data;
        fifo_wr_ptr           <= ~fifo_wr_ptr;
      end
      if (pop) fifo_rd_ptr <= ~fifo_rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  // RAM write port select: the clear sweep shadows any config write.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = config_addr;
    ram_wdata = {staging_hi, config_value};
    if (clear_config) begin
      if (!clr_finished) begin
        ram_we    = 1'b1;
        ram_waddr = clr_ptr;
        ram_wdata = '0;
      end
    end else if (config_enable && (config_byte == 3'd3)) begin
      ram_we = 1'b1;
    end
  end

  // Synapse RAM: registered read returns pre-write data on an address collision.
  always_ff @(posedge clk) begin
    if (issue) rd_data <= ram[idx];
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  // Config staging and the clear sweep counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      staging_hi   <= '0;
      clr_ptr      <= '0;
      clr_finished <= 1'b0;
      clear_done   <= 1'b0;
    end else if (clear_config) begin
      if (!clr_finished) begin
        clr_ptr <= clr_ptr + 12'd1;
        if (clr_ptr == 12'hFFF) clr_finished <= 1'b1;
      end
      clear_done <= clr_finished || (clr_ptr == 12'hFFF);
    end else begin
      clr_ptr      <= '0;
      clr_finished <= 1'b0;
      clear_done   <= 1'b0;
      if (config_enable) begin
        case (config_byte)
          3'd1:    staging_hi <= '0;
          3'd2:    staging_hi <= config_value;
          default: ;
        endcase
      end
    end
  end

  // Idle indication for the timestep controller.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) step_done <= 1'b0;
    else step_done <= (state == IDLE) && (fifo_count == 2'd0) && !inflight &&
                      !syn_if.syn_vld && !clear_config;
  end

endmodule
